fetch_unit: RTL and testbench

Front end of the pipelined 16-bit CPU, directly upstream of fetch_glue. Owns the fetch PC and issues instruction requests to the I-cache. Steers the next PC from the branch predictor and from decode-stage redirects, and presents a registered {pc, instr, instr_valid} fetch packet to fetch_glue and the decode pipeline register. Handles I-cache miss wait, downstream stall, redirect flush and halt.

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_unit_next_pc.sv | 24 ++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants for the 16-bit CPU front end.
package fetch_unit_pkg;

    localparam int unsigned PKG_PC_SIZE = 16;
    localparam int unsigned PKG_INSTR_W = 16;
    localparam logic [PKG_PC_SIZE-1:0] PKG_RESET_PC = '0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MISS   = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PKG_PC_SIZE-1:0] pc;
        logic [PKG_INSTR_W-1:0] instr;
        logic                   valid;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next fetch PC: redirect beats predictor, predictor beats sequential +1.
module fetch_unit_next_pc
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_SIZE = PKG_PC_SIZE
) (
    input  logic               redirect,
    input  logic [PC_SIZE-1:0] redirect_pc,
    input  logic               pc_override,
    input  logic [PC_SIZE-1:0] predict_target,
    input  logic [PC_SIZE-1:0] fetch_pc,
    output logic [PC_SIZE-1:0] next_pc
);

    always_comb begin
        if (redirect)
            next_pc = redirect_pc;
        else if (pc_override)
            next_pc = predict_target;
        else
            next_pc = fetch_pc + {{(PC_SIZE-1){1'b0}}, 1'b1};
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch PC owner: issues I-cache requests and presents a registered fetch packet.
//   state  | meaning
//   RUN    | issuing a request for fetch_pc each unstalled cycle
//   MISS   | last request missed; re-requesting the same fetch_pc
//   HALTED | halt decoded; no requests until reset
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned               PC_SIZE  = PKG_PC_SIZE,
    parameter logic [PC_SIZE-1:0]        RESET_PC = PKG_RESET_PC,
    parameter int unsigned               INSTR_W  = PKG_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_stall,
    input  logic               i_redirect,
    input  logic [PC_SIZE-1:0] i_redirect_pc,
    input  logic               i_halt,
    input  logic               i_pc_override,
    input  logic [PC_SIZE-1:0] i_predict_target,
    output logic [PC_SIZE-1:0] o_fetch_pc,
    output logic               o_icache_req,
    input  logic               i_icache_ready,
    input  logic [INSTR_W-1:0] i_icache_data,
    output logic [PC_SIZE-1:0] o_pc,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_instr_valid,
    output logic               o_halted,
    output logic [15:0]        o_miss_cycles
);

    fetch_state_t       state_q, state_d;
    logic [PC_SIZE-1:0] fetch_pc_q;
    logic [PC_SIZE-1:0] next_pc;
    logic               hit;

    fetch_unit_next_pc #(.PC_SIZE(PC_SIZE)) u_next_pc (
        .redirect       (i_redirect),
        .redirect_pc    (i_redirect_pc),
        .pc_override    (i_pc_override),
        .predict_target (i_predict_target),
        .fetch_pc       (fetch_pc_q),
        .next_pc        (next_pc)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_halt)
            state_d = ST_HALTED;
        else if (state_q == ST_HALTED)
            state_d = ST_HALTED;
        else if (i_redirect)
            state_d = ST_RUN;
        else if (i_stall)
            state_d = state_q;
        else if (hit)
            state_d = ST_RUN;
        else
            state_d = ST_MISS;
    end

    always_comb begin
        o_icache_req = (state_q != ST_HALTED) && !i_stall && !i_redirect;
        hit          = o_icache_req && i_icache_ready;
    end

    // Halt wins over a same-cycle redirect: the redirecting instruction is younger than the halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            o_pc          <= '0;
            o_instr       <= '0;
            o_instr_valid <= 1'b0;
            o_halted      <= 1'b0;
        end else if (i_halt) begin
            o_halted      <= 1'b1;
            o_instr_valid <= 1'b0;
        end else if (state_q == ST_HALTED) begin
            o_halted      <= 1'b1;
        end else if (i_redirect) begin
            fetch_pc_q    <= next_pc;
            o_instr_valid <= 1'b0;
        end else if (i_stall) begin
            o_instr_valid <= o_instr_valid;
        end else if (hit) begin
            o_pc          <= fetch_pc_q;
            o_instr       <= i_icache_data;
            o_instr_valid <= 1'b1;
            fetch_pc_q    <= next_pc;
        end else begin
            o_instr_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            o_miss_cycles <= '0;
        else if (state_q == ST_MISS && !i_stall && o_miss_cycles != 16'hFFFF)
            o_miss_cycles <= o_miss_cycles + 16'd1;
    end

    assign o_fetch_pc = fetch_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios then randomized traffic.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, i_stall, i_redirect, i_halt, i_pc_override, i_icache_ready;
    logic [15:0] i_redirect_pc, i_predict_target, i_icache_data;
    logic [15:0] o_fetch_pc, o_pc, o_instr, o_miss_cycles;
    logic        o_icache_req, o_instr_valid, o_halted;

    fetch_unit dut (
        .clk(clk), .rst(rst), .i_stall(i_stall), .i_redirect(i_redirect),
        .i_redirect_pc(i_redirect_pc), .i_halt(i_halt), .i_pc_override(i_pc_override),
        .i_predict_target(i_predict_target), .o_fetch_pc(o_fetch_pc),
        .o_icache_req(o_icache_req), .i_icache_ready(i_icache_ready),
        .i_icache_data(i_icache_data), .o_pc(o_pc), .o_instr(o_instr),
        .o_instr_valid(o_instr_valid), .o_halted(o_halted), .o_miss_cycles(o_miss_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          edge_id;
        logic [15:0] fpc, opc, instr, misses;
        logic        valid, halted;
    } exp_t;

    exp_t queue_exp[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   edges_seen = 0;

    // Reference model: observable behaviour only.
    logic [15:0] m_pc = 16'h0, m_opc = 16'h0, m_instr = 16'h0, m_misses = 16'h0;
    logic        m_valid = 1'b0, m_halted = 1'b0, m_missing = 1'b0;

    always @(posedge clk) edges_seen <= edges_seen + 1;

    always @(negedge clk) begin
        while (queue_exp.size() > 0 && queue_exp[0].edge_id <= edges_seen) begin
            exp_t e;
            e = queue_exp.pop_front();
            compared++;
            if ({o_instr_valid, o_pc, o_instr} !== {e.valid, e.opc, e.instr}) begin
                mismatched++;
                $display("FAIL packet edge %0d: got v=%b pc=%h instr=%h expected v=%b pc=%h instr=%h",
                         e.edge_id, o_instr_valid, o_pc, o_instr, e.valid, e.opc, e.instr);
            end
            compared++;
            if (o_fetch_pc !== e.fpc) begin
                mismatched++;
                $display("FAIL fetch_pc edge %0d: got %h expected %h", e.edge_id, o_fetch_pc, e.fpc);
            end
            compared++;
            if (o_halted !== e.halted) begin
                mismatched++;
                $display("FAIL halted edge %0d: got %b expected %b", e.edge_id, o_halted, e.halted);
            end
            compared++;
            if (o_miss_cycles !== e.misses) begin
                mismatched++;
                $display("FAIL miss_cycles edge %0d: got %0d expected %0d", e.edge_id, o_miss_cycles, e.misses);
            end
        end
    end

    task automatic step(input logic r, input logic s, input logic rd, input logic [15:0] rpc,
                        input logic h, input logic ov, input logic [15:0] tgt,
                        input logic rdy, input logic [15:0] d);
        logic exp_req;
        exp_t e;
        #1;
        rst = r; i_stall = s; i_redirect = rd; i_redirect_pc = rpc; i_halt = h;
        i_pc_override = ov; i_predict_target = tgt; i_icache_ready = rdy; i_icache_data = d;
        #1;
        exp_req = !m_halted && !s && !rd;
        if (!r) begin
            compared++;
            if (o_icache_req !== exp_req) begin
                mismatched++;
                $display("FAIL icache_req at pc %h: got %b expected %b", m_pc, o_icache_req, exp_req);
            end
        end
        if (r) begin
            m_pc = 16'h0; m_opc = 16'h0; m_instr = 16'h0; m_misses = 16'h0;
            m_valid = 1'b0; m_halted = 1'b0; m_missing = 1'b0;
        end else begin
            if (m_missing && !m_halted && !s && m_misses != 16'hFFFF)
                m_misses = m_misses + 16'd1;
            if (h) begin
                m_halted = 1'b1; m_valid = 1'b0; m_missing = 1'b0;
            end else if (m_halted) begin
                m_halted = 1'b1;
            end else if (rd) begin
                m_pc = rpc; m_valid = 1'b0; m_missing = 1'b0;
            end else if (s) begin
                m_halted = 1'b0;
            end else if (rdy) begin
                m_opc = m_pc; m_instr = d; m_valid = 1'b1; m_missing = 1'b0;
                m_pc = ov ? tgt : m_pc + 16'd1;
            end else begin
                m_valid = 1'b0; m_missing = 1'b1;
            end
        end
        e.edge_id = edges_seen + 1;
        e.fpc = m_pc; e.opc = m_opc; e.instr = m_instr; e.misses = m_misses;
        e.valid = m_valid; e.halted = m_halted;
        queue_exp.push_back(e);
        @(posedge clk);
    endtask

    task automatic hit(input logic [15:0] d);
        step(0, 0, 0, 16'h0, 0, 0, 16'h0, 1, d);
    endtask

    initial begin
        rst = 1; i_stall = 0; i_redirect = 0; i_redirect_pc = 0; i_halt = 0;
        i_pc_override = 0; i_predict_target = 0; i_icache_ready = 0; i_icache_data = 0;
        @(posedge clk);
        step(1, 0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
        for (int i = 0; i < 5; i++) hit(16'hA000 + 16'(i));
        // pc 5 predicted taken to 0x0040
        step(0, 0, 0, 16'h0, 0, 1, 16'h0040, 1, 16'hBEEF);
        step(0, 0, 1, 16'h0008, 0, 0, 16'h0, 1, 16'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
        hit(16'hC008);
        hit(16'hC009);
        step(0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
        step(0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
        step(0, 1, 1, 16'h0100, 0, 0, 16'h0, 1, 16'h0);
        hit(16'hD100);
        step(0, 0, 1, 16'hFFFF, 0, 0, 16'h0, 0, 16'h0);
        hit(16'hEFFF);
        hit(16'hE000);
        step(0, 0, 1, 16'h1234, 1, 0, 16'h0, 1, 16'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 0, 0, 16'h0, 1, 16'h5555);
        step(1, 0, 0, 16'h0, 0, 0, 16'h0, 1, 16'h0);
        for (int i = 0; i < 400; i++) begin
            logic r, s, rd, h, ov, rdy;
            r   = ($urandom_range(0, 99) < 2);
            s   = ($urandom_range(0, 99) < 20);
            rd  = ($urandom_range(0, 99) < 10);
            h   = ($urandom_range(0, 99) < 2);
            ov  = ($urandom_range(0, 99) < 25);
            rdy = ($urandom_range(0, 99) < 70);
            if (m_halted && $urandom_range(0, 3) == 0) r = 1'b1;
            step(r, s, rd, 16'($urandom), h, ov, 16'($urandom), rdy, 16'($urandom));
        end
        step(0, 1, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (queue_exp.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expected packets never checked, required 0", queue_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
